serial_addsub_ctrl: RTL and testbench



---
 rtl/serial_addsub_ctrl_if.sv | 31 +++
 rtl/serial_addsub_ctrl.sv | 121 ++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_ctrl_if.sv
// Handshake/operand bus for the bit-serial add/subtract controller.
// Flag outputs exist only when SERIAL_ADDSUB_FLAGS_EN is defined.
interface serial_addsub_ctrl_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;
`ifdef SERIAL_ADDSUB_FLAGS_EN
   logic             zero;
   logic             neg;
   logic             ovf;
`endif

`ifdef SERIAL_ADDSUB_FLAGS_EN
   modport master (output start, sub, a, b,
                   input  busy, done, result, carry_out, zero, neg, ovf);
   modport slave  (input  start, sub, a, b,
                   output busy, done, result, carry_out, zero, neg, ovf);
`else
   modport master (output start, sub, a, b,
                   input  busy, done, result, carry_out);
   modport slave  (input  start, sub, a, b,
                   output busy, done, result, carry_out);
`endif
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit add/subtract using one full-adder slice, LSB first.
// Optional zero/neg/ovf flags enabled by defining SERIAL_ADDSUB_FLAGS_EN.
module serial_addsub_ctrl #(
   parameter  int unsigned WIDTH = 32,
   localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   serial_addsub_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_res_sr;
   logic [WIDTH-1:0] r_result;
   logic [CNT_W-1:0] r_cnt;
   logic             r_carry;
   logic             r_carry_out;
   logic             r_busy;
   logic             r_done;
`ifdef SERIAL_ADDSUB_FLAGS_EN
   logic             r_zero;
   logic             r_neg;
   logic             r_ovf;
`endif

   logic             w_sum;
   logic             w_cout;
   logic             w_last;
   logic [WIDTH-1:0] w_res_next;

   // Shared full-adder slice and the shift-in view of the result register
   always_comb begin
      w_sum      = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
      w_cout     = (r_a_sr[0] & r_b_sr[0]) | (r_carry & (r_a_sr[0] ^ r_b_sr[0]));
      w_res_next = {w_sum, r_res_sr[WIDTH-1:1]};
      w_last     = (r_cnt == CNT_W'(WIDTH - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_a_sr      <= '0;
         r_b_sr      <= '0;
         r_res_sr    <= '0;
         r_result    <= '0;
         r_cnt       <= '0;
         r_carry     <= 1'b0;
         r_carry_out <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
`ifdef SERIAL_ADDSUB_FLAGS_EN
         r_zero      <= 1'b0;
         r_neg       <= 1'b0;
         r_ovf       <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  // Subtraction is A + ~B + 1: invert B and seed the carry
                  r_a_sr  <= bus.a;
                  r_b_sr  <= bus.sub ? ~bus.b : bus.b;
                  r_carry <= bus.sub;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_res_sr <= w_res_next;
               r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
               r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
               r_carry  <= w_cout;
               r_cnt    <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_result    <= w_res_next;
                  r_carry_out <= w_cout;
`ifdef SERIAL_ADDSUB_FLAGS_EN
                  // r_carry here is the carry into the MSB
                  r_zero      <= (w_res_next == '0);
                  r_neg       <= w_sum;
                  r_ovf       <= r_carry ^ w_cout;
`endif
                  r_busy      <= 1'b0;
                  r_done      <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.result    = r_result;
   assign bus.carry_out = r_carry_out;
`ifdef SERIAL_ADDSUB_FLAGS_EN
   assign bus.zero      = r_zero;
   assign bus.neg       = r_neg;
   assign bus.ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl: WIDTH=8 directed scenarios and
// WIDTH=32 back-to-back random traffic.
module tb_serial_addsub_ctrl;

   typedef struct packed {
      logic [63:0] res;
      logic        c;
      logic        z;
      logic        n;
      logic        v;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_vec;
   int   n_err;
   exp_t sb_q[$];

   serial_addsub_ctrl_if #(.WIDTH(8))  if8();
   serial_addsub_ctrl_if #(.WIDTH(32)) if32();

   serial_addsub_ctrl #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
   serial_addsub_ctrl #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: plain wide addition of A and (B or ~B) plus carry-in
   function automatic exp_t ref_calc(input int w, input logic sub,
                                     input logic [63:0] a, input logic [63:0] b);
      exp_t        e;
      logic [64:0] mask;
      logic [64:0] am;
      logic [64:0] bm;
      logic [64:0] sum;
      mask  = (65'd1 << w) - 65'd1;
      am    = {1'b0, a} & mask;
      bm    = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
      sum   = am + bm + 65'(sub);
      e.res = 64'(sum & mask);
      e.c   = sum[w];
      e.z   = (e.res == 64'd0);
      e.n   = e.res[w-1];
      e.v   = (am[w-1] == bm[w-1]) && (e.res[w-1] != am[w-1]);
      return e;
   endfunction

   task automatic push8(input logic sub, input logic [7:0] a, input logic [7:0] b);
      if8.sub   = sub;
      if8.a     = a;
      if8.b     = b;
      if8.start = 1'b1;
      sb_q.push_back(ref_calc(8, sub, 64'(a), 64'(b)));
   endtask

   // One WIDTH=8 operation: latency, done pulse and scoreboard result
   task automatic do_op8(input string nm, input logic sub,
                         input logic [7:0] a, input logic [7:0] b);
      int   nb;
      exp_t e;
      @(posedge clk); #1;
      push8(sub, a, b);
      @(posedge clk); #1;
      if8.start = 1'b0;
      nb = 0;
      while (if8.busy === 1'b1 && nb < 40) begin
         nb++;
         @(posedge clk); #1;
      end
      n_vec++;
      if (nb !== 8) begin
         n_err++;
         $display("FAIL %s busy_cycles: got %0d want 8", nm, nb);
      end
      n_vec++;
      if (if8.done !== 1'b1) begin
         n_err++;
         $display("FAIL %s done_pulse: got %b want 1", nm, if8.done);
      end
      e = sb_q.pop_front();
      n_vec++;
      if (if8.result !== e.res[7:0] || if8.carry_out !== e.c) begin
         n_err++;
         $display("FAIL %s result: got %h/%b want %h/%b", nm, if8.result,
                  if8.carry_out, e.res[7:0], e.c);
      end
`ifdef SERIAL_ADDSUB_FLAGS_EN
      n_vec++;
      if ({if8.zero, if8.neg, if8.ovf} !== {e.z, e.n, e.v}) begin
         n_err++;
         $display("FAIL %s flags(z,n,v): got %b%b%b want %b%b%b", nm,
                  if8.zero, if8.neg, if8.ovf, e.z, e.n, e.v);
      end
`endif
      @(posedge clk); #1;
      n_vec++;
      if (if8.done !== 1'b0 || if8.result !== e.res[7:0]) begin
         n_err++;
         $display("FAIL %s done_clear_hold: got done=%b res=%h want 0/%h", nm,
                  if8.done, if8.result, e.res[7:0]);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({if8.busy, if8.done, if8.result, if8.carry_out} !== 11'd0 ||
          {if32.busy, if32.done, if32.result, if32.carry_out} !== 35'd0) begin
         n_err++;
         $display("FAIL reset_state: got %b%b%h%b want all 0", if8.busy, if8.done,
                  if8.result, if8.carry_out);
      end
      #4 rst_n = 1'b1;
   endtask

   task automatic test_add();
      do_op8("add_7f_01", 1'b0, 8'h7F, 8'h01);
      do_op8("add_ff_01", 1'b0, 8'hFF, 8'h01);
   endtask

   task automatic test_sub();
      do_op8("sub_05_07", 1'b1, 8'h05, 8'h07);
      do_op8("sub_07_05", 1'b1, 8'h07, 8'h05);
   endtask

   task automatic test_start_ignored();
      int   nd;
      exp_t e;
      logic [7:0] r;
      @(posedge clk); #1;
      push8(1'b0, 8'h7F, 8'h01);
      @(posedge clk); #1;
      if8.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      if8.sub = 1'b1; if8.a = 8'h11; if8.b = 8'h22; if8.start = 1'b1;
      @(posedge clk); #1;
      if8.start = 1'b0;
      nd = 0;
      r  = 8'h00;
      for (int i = 0; i < 14; i++) begin
         if (if8.done === 1'b1) begin
            nd++;
            r = if8.result;
         end
         @(posedge clk); #1;
      end
      e = sb_q.pop_front();
      n_vec++;
      if (nd !== 1) begin
         n_err++;
         $display("FAIL ignore_start done_count: got %0d want 1", nd);
      end
      n_vec++;
      if (r !== e.res[7:0]) begin
         n_err++;
         $display("FAIL ignore_start result: got %h want %h", r, e.res[7:0]);
      end
   endtask

   task automatic test_async_reset();
      @(posedge clk); #1;
      if8.sub = 1'b0; if8.a = 8'h55; if8.b = 8'h11; if8.start = 1'b1;
      @(posedge clk); #1;
      if8.start = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({if8.busy, if8.done, if8.result, if8.carry_out} !== 11'd0) begin
         n_err++;
         $display("FAIL async_reset: got busy=%b done=%b res=%h co=%b want 0",
                  if8.busy, if8.done, if8.result, if8.carry_out);
      end
      @(posedge clk); #4;
      rst_n = 1'b1;
      do_op8("after_reset", 1'b0, 8'h10, 8'h20);
   endtask

   // WIDTH=32: start held high, new operands presented as each result lands
   task automatic test_back_to_back();
      localparam int N = 1000;
      int   last;
      int   wt;
      exp_t e;
      logic [31:0] ra, rb;
      logic rs;
      last = 0;
      @(posedge clk); #1;
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      if32.a = ra; if32.b = rb; if32.sub = rs; if32.start = 1'b1;
      sb_q.push_back(ref_calc(32, rs, 64'(ra), 64'(rb)));
      for (int i = 0; i < N; i++) begin
         wt = 0;
         @(posedge clk); #1;
         while (if32.done !== 1'b1 && wt < 60) begin
            wt++;
            @(posedge clk); #1;
         end
         if (if32.done !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL b2b timeout: op %0d no done within bound", i);
            if32.start = 1'b0;
            return;
         end
         if (i > 0) begin
            n_vec++;
            if (cyc - last !== 34) begin
               n_err++;
               $display("FAIL b2b interval: op %0d got %0d want 34", i, cyc - last);
            end
         end
         last = cyc;
         e = sb_q.pop_front();
         n_vec++;
         if (if32.result !== e.res[31:0] || if32.carry_out !== e.c) begin
            n_err++;
            $display("FAIL b2b result: op %0d got %h/%b want %h/%b", i,
                     if32.result, if32.carry_out, e.res[31:0], e.c);
         end
`ifdef SERIAL_ADDSUB_FLAGS_EN
         n_vec++;
         if ({if32.zero, if32.neg, if32.ovf} !== {e.z, e.n, e.v}) begin
            n_err++;
            $display("FAIL b2b flags: op %0d got %b%b%b want %b%b%b", i,
                     if32.zero, if32.neg, if32.ovf, e.z, e.n, e.v);
         end
`endif
         if (i < N - 1) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            if32.a = ra; if32.b = rb; if32.sub = rs;
            sb_q.push_back(ref_calc(32, rs, 64'(ra), 64'(rb)));
         end else begin
            if32.start = 1'b0;
         end
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      if8.start  = 1'b0; if8.sub  = 1'b0; if8.a  = '0; if8.b  = '0;
      if32.start = 1'b0; if32.sub = 1'b0; if32.a = '0; if32.b = '0;
      test_reset();
      test_add();
      test_sub();
      test_start_ignored();
      test_async_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
